// File: rtl/riot_bus_ctl.sv
// RIOT register front end: decodes CPU cycles into port/DDR, PA7 edge control and timer load strobes.
// Read mux and strobes are combinational; flags and registers update on the rising CLK edge.
module riot_bus_ctl (
  input  logic       CLK,
  input  logic       RES,
  input  logic       CS,
  input  logic       RW,
  input  logic [4:0] A,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  input  logic [7:0] PA_IN,
  input  logic [7:0] PB_IN,
  output logic [7:0] PA_OUT,
  output logic [7:0] PB_OUT,
  output logic [7:0] PA_DDR,
  output logic [7:0] PB_DDR,
  output logic       TIM_WE,
  output logic [1:0] TIM_MODE,
  output logic [7:0] TIM_IN,
  input  logic [7:0] TIM_VAL,
  output logic       IRQ_N
);

  logic [7:0] r_ora, r_ddra, r_orb, r_ddrb;
  logic       r_tie, r_pie, r_pedge, r_tf, r_pf;
  logic [7:0] r_tv_q;
  logic       r_we_q, r_pa7_q;

  logic w_wr, w_rd, w_port_wr, w_tim_load, w_edge_wr, w_tim_rd, w_flag_rd;
  logic w_expire, w_pa7_edge;

  assign w_wr       = CS & ~RW;
  assign w_rd       = CS & RW;
  assign w_port_wr  = w_wr & ~A[2];
  assign w_tim_load = w_wr & A[2] & A[4];
  assign w_edge_wr  = w_wr & A[2] & ~A[4];
  assign w_tim_rd   = w_rd & A[2] & ~A[0];
  assign w_flag_rd  = w_rd & A[2] & A[0];

  // Timer wrapped past zero; a load in this or the previous cycle is not an expiry.
  assign w_expire   = (r_tv_q == 8'h00) & (TIM_VAL != 8'h00) & ~r_we_q & ~w_tim_load;
  assign w_pa7_edge = (r_pa7_q == ~r_pedge) & (PA_IN[7] == r_pedge);

  assign TIM_WE   = w_tim_load;
  assign TIM_MODE = A[1:0];
  assign TIM_IN   = DIN;
  assign PA_OUT   = r_ora;
  assign PA_DDR   = r_ddra;
  assign PB_OUT   = r_orb;
  assign PB_DDR   = r_ddrb;
  assign IRQ_N    = ~((r_tf & r_tie) | (r_pf & r_pie));

  always_comb begin
    DOUT = 8'h00;
    if (w_rd) begin
      if (!A[2]) begin
        case (A[1:0])
          2'd0:    DOUT = PA_IN;
          2'd1:    DOUT = r_ddra;
          2'd2:    DOUT = (r_orb & r_ddrb) | (PB_IN & ~r_ddrb);
          default: DOUT = r_ddrb;
        endcase
      end else if (!A[0]) begin
        DOUT = TIM_VAL;
      end else begin
        DOUT = {r_tf, r_pf, 6'b0};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_ora   <= 8'h00;
      r_ddra  <= 8'h00;
      r_orb   <= 8'h00;
      r_ddrb  <= 8'h00;
      r_tie   <= 1'b0;
      r_pie   <= 1'b0;
      r_pedge <= 1'b0;
      r_tf    <= 1'b0;
      r_pf    <= 1'b0;
      r_tv_q  <= 8'h00;
      r_we_q  <= 1'b0;
      r_pa7_q <= 1'b0;
    end else begin
      if (w_port_wr) begin
        case (A[1:0])
          2'd0:    r_ora  <= DIN;
          2'd1:    r_ddra <= DIN;
          2'd2:    r_orb  <= DIN;
          default: r_ddrb <= DIN;
        endcase
      end
      if (w_tim_load || w_tim_rd)
        r_tie <= A[3];
      if (w_edge_wr) begin
        r_pedge <= A[0];
        r_pie   <= A[1];
      end
      // Set events win over clear-on-read in the same cycle.
      if (w_expire)
        r_tf <= 1'b1;
      else if (w_tim_load || w_tim_rd)
        r_tf <= 1'b0;
      if (w_pa7_edge)
        r_pf <= 1'b1;
      else if (w_flag_rd)
        r_pf <= 1'b0;
      r_tv_q  <= TIM_VAL;
      r_we_q  <= w_tim_load;
      r_pa7_q <= PA_IN[7];
    end
  end

endmodule

// File: tb/tb_riot_bus_ctl.sv
// Self-checking bench for riot_bus_ctl: per-cycle vector table plus hand sequences for flag corner cases.
module tb_riot_bus_ctl;

  logic       CLK, RES, CS, RW;
  logic [4:0] A;
  logic [7:0] DIN, DOUT, PA_IN, PB_IN, PA_OUT, PB_OUT, PA_DDR, PB_DDR;
  logic       TIM_WE;
  logic [1:0] TIM_MODE;
  logic [7:0] TIM_IN, TIM_VAL;
  logic       IRQ_N;

  int checks = 0;
  int errors = 0;

  riot_bus_ctl dut (
    .CLK(CLK), .RES(RES), .CS(CS), .RW(RW), .A(A), .DIN(DIN), .DOUT(DOUT),
    .PA_IN(PA_IN), .PB_IN(PB_IN), .PA_OUT(PA_OUT), .PB_OUT(PB_OUT),
    .PA_DDR(PA_DDR), .PB_DDR(PB_DDR), .TIM_WE(TIM_WE), .TIM_MODE(TIM_MODE),
    .TIM_IN(TIM_IN), .TIM_VAL(TIM_VAL), .IRQ_N(IRQ_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] dout;
    logic       irq_n;
    logic       tim_we;
    logic [7:0] pa_out, pa_ddr, pb_out, pb_ddr;
  } exp_t;

  typedef struct {
    logic       res, cs, rw;
    logic [4:0] a;
    logic [7:0] din, pa, pb, tv;
    exp_t       e;
  } vec_t;

  vec_t tbl[24];
  exp_t sb[$];

  function automatic vec_t mk(input logic res, cs, rw, input logic [4:0] a,
                              input logic [7:0] din, pa, pb, tv, dout,
                              input logic irq_n, tim_we,
                              input logic [7:0] pao, pad, pbo, pbd);
    vec_t v;
    v.res = res; v.cs = cs; v.rw = rw; v.a = a;
    v.din = din; v.pa = pa; v.pb = pb; v.tv = tv;
    v.e.dout = dout; v.e.irq_n = irq_n; v.e.tim_we = tim_we;
    v.e.pa_out = pao; v.e.pa_ddr = pad; v.e.pb_out = pbo; v.e.pb_ddr = pbd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Apply one bus cycle at the falling edge; the next falling edge is past the commit edge.
  task automatic drive(input logic res, cs, rw, input logic [4:0] a,
                       input logic [7:0] din, pa, pb, tv);
    @(negedge CLK);
    RES = res; CS = cs; RW = rw; A = a; DIN = din;
    PA_IN = pa; PB_IN = pb; TIM_VAL = tv;
  endtask

  initial begin
    exp_t e;
    RES = 1'b1; CS = 1'b0; RW = 1'b0; A = 5'd0; DIN = 8'h00;
    PA_IN = 8'h00; PB_IN = 8'h3C; TIM_VAL = 8'h00;

    drive(1, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h00);
    drive(1, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h00);
    drive(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h00);
    #1;
    chk("rst_pa_out", PA_OUT, 8'h00);
    chk("rst_pa_ddr", PA_DDR, 8'h00);
    chk("rst_pb_out", PB_OUT, 8'h00);
    chk("rst_pb_ddr", PB_DDR, 8'h00);
    chk("rst_irq_n", {7'd0, IRQ_N}, 8'h01);
    chk("rst_tim_we", {7'd0, TIM_WE}, 8'h00);

    //            res cs rw a         din    pa     pb     tv     dout   irq we pao    pad    pbo    pbd
    tbl[0]  = mk(0, 1, 0, 5'b00011, 8'h0F, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(0, 1, 0, 5'b00010, 8'hA5, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00, 8'h0F);
    tbl[2]  = mk(0, 1, 1, 5'b00010, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h35, 1, 0, 8'h00, 8'h00, 8'hA5, 8'h0F);
    tbl[3]  = mk(0, 1, 0, 5'b00000, 8'h5A, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 8'hA5, 8'h0F);
    tbl[4]  = mk(0, 1, 0, 5'b00001, 8'hC3, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 0, 8'h5A, 8'h00, 8'hA5, 8'h0F);
    tbl[5]  = mk(0, 1, 1, 5'b00001, 8'h00, 8'h00, 8'h3C, 8'h00, 8'hC3, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[6]  = mk(0, 1, 1, 5'b00000, 8'h00, 8'h77, 8'h3C, 8'h00, 8'h77, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[7]  = mk(0, 1, 1, 5'b00011, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h0F, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[8]  = mk(0, 0, 1, 5'b00010, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[9]  = mk(0, 1, 0, 5'b11101, 8'h03, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 1, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[10] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[11] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[12] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[13] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 0, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[14] = mk(0, 1, 1, 5'b00100, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h01, 0, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[15] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[16] = mk(0, 1, 1, 5'b00101, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[17] = mk(0, 1, 0, 5'b00111, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[18] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h80, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[19] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h80, 8'h3C, 8'h01, 8'h00, 0, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[20] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 0, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[21] = mk(0, 1, 1, 5'b00101, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h40, 0, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[22] = mk(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);
    tbl[23] = mk(0, 1, 1, 5'b00101, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 1, 0, 8'h5A, 8'hC3, 8'hA5, 8'h0F);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].res, tbl[i].cs, tbl[i].rw, tbl[i].a, tbl[i].din,
            tbl[i].pa, tbl[i].pb, tbl[i].tv);
      sb.push_back(tbl[i].e);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_dout", i), DOUT, e.dout);
      chk($sformatf("v%0d_irq_n", i), {7'd0, IRQ_N}, {7'd0, e.irq_n});
      chk($sformatf("v%0d_tim_we", i), {7'd0, TIM_WE}, {7'd0, e.tim_we});
      chk($sformatf("v%0d_pa_out", i), PA_OUT, e.pa_out);
      chk($sformatf("v%0d_pa_ddr", i), PA_DDR, e.pa_ddr);
      chk($sformatf("v%0d_pb_out", i), PB_OUT, e.pb_out);
      chk($sformatf("v%0d_pb_ddr", i), PB_DDR, e.pb_ddr);
    end

    // Expiry coinciding with a timer-value read: set wins.
    drive(0, 1, 0, 5'b11101, 8'h03, 8'h00, 8'h3C, 8'h01);
    #1;
    chk("load_we", {7'd0, TIM_WE}, 8'h01);
    chk("load_mode", {6'd0, TIM_MODE}, 8'h01);
    chk("load_in", TIM_IN, 8'h03);
    drive(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h00);
    #1;
    chk("load_we_drop", {7'd0, TIM_WE}, 8'h00);
    chk("load_irq", {7'd0, IRQ_N}, 8'h01);
    drive(0, 1, 1, 5'b01100, 8'h00, 8'h00, 8'h3C, 8'h01);
    #1;
    chk("rd_tv_dout", DOUT, 8'h01);
    drive(0, 1, 1, 5'b00101, 8'h00, 8'h00, 8'h3C, 8'h01);
    #1;
    chk("rd_collide_flags", DOUT, 8'h80);
    chk("rd_collide_irq", {7'd0, IRQ_N}, 8'h00);

    // Load while the value leaves zero: TF cleared, expiry suppressed.
    drive(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h00);
    #1;
    chk("pre_load_irq", {7'd0, IRQ_N}, 8'h00);
    drive(0, 1, 0, 5'b11101, 8'h05, 8'h00, 8'h3C, 8'h01);
    drive(0, 0, 0, 5'b00000, 8'h00, 8'h00, 8'h3C, 8'h01);
    #1;
    chk("load_collide_irq", {7'd0, IRQ_N}, 8'h01);
    drive(0, 1, 1, 5'b00101, 8'h00, 8'h00, 8'h3C, 8'h01);
    #1;
    chk("load_collide_flags", DOUT, 8'h00);

    // Reset during an ORA write with PF pending.
    drive(0, 0, 0, 5'b00000, 8'h00, 8'h80, 8'h3C, 8'h01);
    drive(0, 0, 0, 5'b00000, 8'h00, 8'h80, 8'h3C, 8'h01);
    #1;
    chk("pf_pending_irq", {7'd0, IRQ_N}, 8'h00);
    drive(1, 1, 0, 5'b00000, 8'hFF, 8'h80, 8'h3C, 8'h00);
    drive(0, 0, 0, 5'b00000, 8'h00, 8'h80, 8'h3C, 8'h00);
    #1;
    chk("mid_rst_pa_out", PA_OUT, 8'h00);
    chk("mid_rst_pa_ddr", PA_DDR, 8'h00);
    chk("mid_rst_pb_out", PB_OUT, 8'h00);
    chk("mid_rst_pb_ddr", PB_DDR, 8'h00);
    chk("mid_rst_irq", {7'd0, IRQ_N}, 8'h01);
    drive(0, 1, 1, 5'b00101, 8'h00, 8'h80, 8'h3C, 8'h00);
    #1;
    chk("mid_rst_flags", DOUT, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
